// File: rtl/reg_file_pkg.sv
// Shared types and defaults for the general-purpose register file.
//   rf_state_t : clear-engine state encoding
//   rf_depth() : number of registers addressed by an address of a given width
//   RF_DATA_W_DEF / RF_ADDR_W_DEF : default geometry, also used by the control unit
package reg_file_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } rf_state_t;

  localparam int RF_DATA_W_DEF = 8;
  localparam int RF_ADDR_W_DEF = 3;

  // Guards against a zero/negative width producing a zero-depth array.
  function automatic int rf_depth(input int addr_w);
    return (addr_w < 1) ? 1 : (1 << addr_w);
  endfunction

endpackage

// File: rtl/reg_file_dec_onehot.sv
// dec_onehot: combinational ADDR_W -> 2**ADDR_W one-hot decoder with enable.
//   en   in  1              all outputs low when en = 0
//   addr in  ADDR_W         index of the output to raise
//   sel  out 2**ADDR_W      one-hot select
module dec_onehot #(
  parameter int ADDR_W = 3
) (
  input  logic                     en,
  input  logic [ADDR_W-1:0]        addr,
  output logic [(1<<ADDR_W)-1:0]   sel
);

  always_comb begin
    sel = '0;
    if (en) sel[addr] = 1'b1;
  end

endmodule

// File: rtl/reg_file_dec.sv
// reg_file_dec: DEPTH x DATA_W register file, one write port, two registered
// read ports, and a clear-all engine that walks every register in DEPTH cycles.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   wr_en/wr_addr/wr_data write request
//   wr_ack, wr_sel        pulse + one-hot decode of the write accepted last edge
//   rd_addr_a/rd_data_a   read port A (1-cycle latency)
//   rd_addr_b/rd_data_b   read port B (1-cycle latency)
//   clr_req, busy         start clear-all (sampled in IDLE) / clear running
//
// Build option: define REG_FILE_BYPASS_EN to forward an accepted write to a
// read port addressing the same register in the same cycle.
//
// state | meaning
// IDLE  | normal operation, writes accepted unless clr_req is high
// CLEAR | reg[cnt] <= RESET_VAL each cycle, writes dropped, busy high
module reg_file_dec
  import reg_file_pkg::*;
#(
  parameter int                DATA_W    = RF_DATA_W_DEF,
  parameter int                ADDR_W    = RF_ADDR_W_DEF,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [ADDR_W-1:0]             wr_addr,
  input  logic [DATA_W-1:0]             wr_data,
  output logic                          wr_ack,
  output logic [rf_depth(ADDR_W)-1:0]   wr_sel,
  input  logic [ADDR_W-1:0]             rd_addr_a,
  output logic [DATA_W-1:0]             rd_data_a,
  input  logic [ADDR_W-1:0]             rd_addr_b,
  output logic [DATA_W-1:0]             rd_data_b,
  input  logic                          clr_req,
  output logic                          busy
);

  localparam int                DEPTH    = rf_depth(ADDR_W);
  localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(DEPTH - 1);

  rf_state_t               state;
  logic [ADDR_W-1:0]       cnt;
  logic [DATA_W-1:0]       mem [DEPTH];

  logic                    is_clear;
  logic                    wr_acc;
  logic [ADDR_W-1:0]       dec_addr;
  logic [DEPTH-1:0]        strb;
  logic [DATA_W-1:0]       strb_data;
  logic [DATA_W-1:0]       rd_mux_a;
  logic [DATA_W-1:0]       rd_mux_b;

  assign is_clear  = (state == CLEAR);
  // clr_req in IDLE wins over a same-cycle write.
  assign wr_acc    = wr_en && (state == IDLE) && !clr_req;
  // One decoder serves both the write port and the clear engine.
  assign dec_addr  = is_clear ? cnt : wr_addr;
  assign strb_data = is_clear ? RESET_VAL : wr_data;

  dec_onehot #(.ADDR_W(ADDR_W)) u_dec (
    .en   (wr_acc || is_clear),
    .addr (dec_addr),
    .sel  (strb)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= RESET_VAL;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (strb[i]) mem[i] <= strb_data;
      end
    end
  end

`ifdef REG_FILE_BYPASS_EN
  assign rd_mux_a = (wr_acc && (rd_addr_a == wr_addr)) ? wr_data : mem[rd_addr_a];
  assign rd_mux_b = (wr_acc && (rd_addr_b == wr_addr)) ? wr_data : mem[rd_addr_b];
`else
  assign rd_mux_a = mem[rd_addr_a];
  assign rd_mux_b = mem[rd_addr_b];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_a <= '0;
      rd_data_b <= '0;
      wr_ack    <= 1'b0;
      wr_sel    <= '0;
    end else begin
      rd_data_a <= rd_mux_a;
      rd_data_b <= rd_mux_b;
      wr_ack    <= wr_acc;
      // strb holds the write decode whenever wr_acc is high (only in IDLE).
      wr_sel    <= wr_acc ? strb : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (clr_req) begin
            state <= CLEAR;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        CLEAR: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_file_dec.sv
module tb_reg_file_dec;

`ifdef REG_FILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [2:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       wr_ack;
  logic [7:0] wr_sel;
  logic [2:0] rd_addr_a = '0;
  logic [7:0] rd_data_a;
  logic [2:0] rd_addr_b = '0;
  logic [7:0] rd_data_b;
  logic       clr_req = 1'b0;
  logic       busy;

  always #5 clk = ~clk;

  reg_file_dec dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ack(wr_ack), .wr_sel(wr_sel),
    .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a),
    .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b),
    .clr_req(clr_req), .busy(busy)
  );

  typedef struct {
    bit       rst, we, clr;
    bit [2:0] wa, ra, rb;
    bit [7:0] wd;
    bit       e_ack, e_busy;
    bit [7:0] e_sel, e_a, e_b;
  } vec_t;

  typedef struct {
    bit       ack, bsy;
    bit [7:0] sel, a, b;
  } exp_t;

  vec_t vq[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(bit r, bit we, bit [2:0] wa, bit [7:0] wd, bit [2:0] ra,
                              bit [2:0] rb, bit clr, bit e_ack, bit [7:0] e_sel,
                              bit [7:0] e_a, bit [7:0] e_b, bit e_busy);
    vec_t v;
    v.rst = r; v.we = we; v.wa = wa; v.wd = wd; v.ra = ra; v.rb = rb; v.clr = clr;
    v.e_ack = e_ack; v.e_sel = e_sel; v.e_a = e_a; v.e_b = e_b; v.e_busy = e_busy;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d: got 0x%02h expected 0x%02h", name, idx, act, exp);
    end
  endtask

  initial begin
    exp_t e;
    int   n;
    bit [7:0] x3c;
    x3c = BYP ? 8'h3C : 8'h00;

    // Reset, then read every address on both ports.
    vq.push_back(mk(1, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0));
    for (int i = 0; i < 8; i++)
      vq.push_back(mk(0, 0, 0, 8'h00, 3'(i), 3'(7 - i), 0, 0, 8'h00, 8'h00, 8'h00, 0));
    // Write 0xA5 @3, then read it back.
    vq.push_back(mk(0, 1, 3, 8'hA5, 0, 0, 0, 1, 8'h08, 8'h00, 8'h00, 0));
    vq.push_back(mk(0, 0, 0, 8'h00, 3, 3, 0, 0, 8'h00, 8'hA5, 8'hA5, 0));
    // Same-cycle write and read @5: old data unless forwarding is built in.
    vq.push_back(mk(0, 1, 5, 8'h3C, 5, 5, 0, 1, 8'h20, x3c, x3c, 0));
    vq.push_back(mk(0, 0, 0, 8'h00, 5, 3, 0, 0, 8'h00, 8'h3C, 8'hA5, 0));
    // Top address boundary.
    vq.push_back(mk(0, 1, 7, 8'h77, 0, 0, 0, 1, 8'h80, 8'h00, 8'h00, 0));
    // Fill 0x11..0x88, each cycle reading the previously written address.
    for (int i = 0; i < 8; i++)
      vq.push_back(mk(0, 1, 3'(i), 8'(8'h11 * (i + 1)), 3'(i + 7), 3'(i + 7), 0, 1, 8'(1 << i),
                      (i == 0) ? 8'h77 : 8'(8'h11 * i), (i == 0) ? 8'h77 : 8'(8'h11 * i), 0));
    for (int i = 0; i < 8; i++)
      vq.push_back(mk(0, 0, 0, 8'h00, 3'(i), 3'(7 - i), 0, 0, 8'h00,
                      8'(8'h11 * (i + 1)), 8'(8'h11 * (8 - i)), 0));
    // Clear: busy for exactly 8 samples; reads see registers before each clear edge.
    // A write of 0xFF @2 during CLEAR must be dropped; clr_req held meanwhile is ignored.
    vq.push_back(mk(0, 0, 0, 8'h00, 0, 0, 1, 0, 8'h00, 8'h11, 8'h11, 1));
    for (int j = 1; j <= 8; j++)
      vq.push_back(mk(0, (j == 2), 2, 8'hFF, 7, 3'(j - 1), (j <= 3), 0, 8'h00,
                      8'h88, 8'(8'h11 * j), (j < 8)));
    for (int i = 0; i < 8; i++)
      vq.push_back(mk(0, 0, 0, 8'h00, 3'(i), 3'(7 - i), 0, 0, 8'h00, 8'h00, 8'h00, 0));
    // Writes resume after clear.
    vq.push_back(mk(0, 1, 2, 8'h5A, 0, 0, 0, 1, 8'h04, 8'h00, 8'h00, 0));
    vq.push_back(mk(0, 1, 7, 8'h66, 2, 2, 0, 1, 8'h80, 8'h5A, 8'h5A, 0));
    // clr_req with a same-cycle write: write dropped. Then rst on the 3rd CLEAR edge.
    vq.push_back(mk(0, 1, 4, 8'hEE, 7, 2, 1, 0, 8'h00, 8'h66, 8'h5A, 1));
    vq.push_back(mk(0, 0, 0, 8'h00, 7, 7, 0, 0, 8'h00, 8'h66, 8'h66, 1));
    vq.push_back(mk(0, 0, 0, 8'h00, 7, 7, 0, 0, 8'h00, 8'h66, 8'h66, 1));
    vq.push_back(mk(1, 0, 0, 8'h00, 7, 7, 0, 0, 8'h00, 8'h00, 8'h00, 0));
    for (int i = 0; i < 8; i++)
      vq.push_back(mk(0, 0, 0, 8'h00, 3'(i), 3'(7 - i), 0, 0, 8'h00, 8'h00, 8'h00, 0));
    vq.push_back(mk(0, 1, 6, 8'h99, 0, 0, 0, 1, 8'h40, 8'h00, 8'h00, 0));
    vq.push_back(mk(0, 0, 0, 8'h00, 6, 4, 0, 0, 8'h00, 8'h99, 8'h00, 0));

    @(negedge clk);
    foreach (vq[k]) begin
      rst = vq[k].rst; wr_en = vq[k].we; wr_addr = vq[k].wa; wr_data = vq[k].wd;
      rd_addr_a = vq[k].ra; rd_addr_b = vq[k].rb; clr_req = vq[k].clr;
      e.ack = vq[k].e_ack; e.sel = vq[k].e_sel; e.a = vq[k].e_a; e.b = vq[k].e_b;
      e.bsy = vq[k].e_busy;
      sb.push_back(e);
      @(posedge clk); #1;
      e = sb.pop_front();
      chk("wr_ack", k, {7'd0, wr_ack}, {7'd0, e.ack});
      chk("wr_sel", k, wr_sel, e.sel);
      chk("rd_data_a", k, rd_data_a, e.a);
      chk("rd_data_b", k, rd_data_b, e.b);
      chk("busy", k, {7'd0, busy}, {7'd0, e.bsy});
    end

    // Hand sequence: count busy cycles of a fresh clear, bounded.
    rst = 1'b0; wr_en = 1'b0; clr_req = 1'b1;
    @(posedge clk); #1;
    clr_req = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 20) begin
      n++;
      @(posedge clk); #1;
    end
    chk("busy_len", 0, 8'(n), 8'd8);
    rd_addr_a = 3'd6; rd_addr_b = 3'd6;
    @(posedge clk); #1;
    chk("post_clr_a", 0, rd_data_a, 8'h00);
    chk("post_clr_b", 0, rd_data_b, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
